// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    DRAIN
  } fetch_state_e;

  // Clear the byte-offset bits so an address points at an instruction word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;

  // Pop-before-push ordering makes push+pop legal even when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, stale-response dropping
// after redirect, and a small queue feeding the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_next;
  logic [CNT_W-1:0] q_count;
  logic             req_fire;
  logic             resp_drop;
  logic             resp_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  fetch_entry_t     q_head;
  fetch_entry_t     q_entry;

  // Requests are credited against both in-flight and buffered work.
  assign imem_req_valid = (state != RESET) && !redirect_valid &&
                          ((SUM_W'(outstanding) + SUM_W'(q_count)) < SUM_W'(DEPTH));
  assign imem_req_addr  = word_align(fetch_pc);
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_drop      = imem_resp_valid & (drop_cnt != '0);
  assign resp_push      = imem_resp_valid & ~resp_drop;
  assign q_pop          = instr_valid & instr_ready;
  assign q_entry        = '{pc: resp_pc, instr: imem_resp_data};

  assign instr_valid = ~q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;

  // Everything in flight after a redirect is stale and must be discarded.
  always_comb begin
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    drop_cnt_next    = drop_cnt;
    state_next       = state;
    if (redirect_valid)  drop_cnt_next = outstanding_next;
    else if (resp_drop)  drop_cnt_next = drop_cnt - 1'b1;
    unique case (state)
      RESET:   state_next = RUN;
      RUN:     if (redirect_valid && (drop_cnt_next != '0)) state_next = DRAIN;
      DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
      default: state_next = RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RESET;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
        if (resp_push) resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (resp_push & (~q_full | q_pop)),
    .push_data(q_entry),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

endmodule
